// File: rtl/multicycle_controller_pkg.sv
// riscv_mc_pkg: shared types and encodings for the multicycle RV32I controller.
package riscv_mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// mc_alu_decoder: maps ALUOp and funct fields to ALUControl, flagging unsupported funct3.
module mc_alu_decoder
    import riscv_mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        if (alu_op == ALUOP_SUB)
            alu_control = ALU_SUB;
        else if (alu_op == ALUOP_FUNCT)
            case (funct3)
                3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: illegal = 1'b1;
            endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM sequencing the shared-memory multicycle RV32I datapath.
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       trap
);
    state_t  state, state_next;
    alu_op_t alu_op;
    logic    illegal, ready;
    logic    pc_write, mem_write, ir_write, reg_write, done;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mc_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl),
        .illegal     (illegal)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_FETCH;
        else        state <= state_next;

    always_comb begin
        state_next = state;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        done       = 1'b0;
        trap       = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
                state_next = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                             (op == OP_R)   ? S_EXECR  :
                             (op == OP_I)   ? S_EXECI  :
                             (op == OP_BR)  ? S_BRANCH :
                             (op == OP_JAL) ? S_JAL    : S_TRAP;
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_write  = 1'b1;
                done       = ready;
                state_next = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                alu_op     = ALUOP_FUNCT;
                state_next = illegal ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                // funct3[0] distinguishes bne from beq
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_SUB;
                pc_write   = Zero ^ funct3[0];
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_TRAP: trap = 1'b1;
            default: state_next = S_FETCH;
        endcase
    end

    assign ImmSrc = (op == OP_SW)  ? IMM_S :
                    (op == OP_BR)  ? IMM_B :
                    (op == OP_JAL) ? IMM_J : IMM_I;

    // Enables are forced low while reset is held so no partial writes escape.
    assign PCWrite    = reset & pc_write;
    assign MemWrite   = reset & mem_write;
    assign IRWrite    = reset & ir_write;
    assign RegWrite   = reset & reg_write;
    assign instr_done = reset & done;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scoreboard bench for the multicycle controller FSM.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [17:0] obs;
    logic [17:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUControl, instr_done, trap};

    function automatic logic [17:0] v(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, sa, sb, imm,
                                      input logic [2:0] alu, input logic dn, tr);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, dn, tr};
    endfunction

    function automatic logic [17:0] e_fetch(input logic r, input logic [1:0] imm);
        return v(r, 0, 0, r, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] e_decode(input logic [1:0] imm);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] e_exec(input logic [1:0] sb, imm, input logic [2:0] alu);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, imm, alu, 0, 0);
    endfunction
    function automatic logic [17:0] e_aluwb(input logic [1:0] imm);
        return v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
    endfunction

    // Expected value is queued as the step is driven, then popped at the sampling edge.
    task automatic step(input string tag, input logic [17:0] e);
        logic [17:0] x;
        string       t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === x) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", t, obs, x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    logic [2:0] itab_f3[4]  = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic       itab_f7[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] itab_alu[4] = '{3'b000, 3'b101, 3'b011, 3'b010};

    initial begin
        reset = 1'b0;
        mem_ready = 1'b1;
        Zero = 1'b0;
        set_ir(7'b0000000, 3'b000, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) step("reset", e_fetch(0, 2'b00));
        reset = 1'b1;

        // addi x1,x0,5
        set_ir(7'b0010011, 3'b000, 1'b0);
        step("addi_fetch", e_fetch(1, 2'b00));
        step("addi_decode", e_decode(2'b00));
        step("addi_execi", e_exec(2'b01, 2'b00, 3'b000));
        step("addi_aluwb", e_aluwb(2'b00));

        // lw with two wait cycles in MEMREAD
        set_ir(7'b0000011, 3'b010, 1'b0);
        step("lw_fetch", e_fetch(1, 2'b00));
        step("lw_decode", e_decode(2'b00));
        step("lw_memadr", e_exec(2'b01, 2'b00, 3'b000));
        mem_ready = 1'b0;
        step("lw_memread_w1", v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("lw_memread_w2", v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        mem_ready = 1'b1;
        step("lw_memread_ok", v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("lw_memwb", v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        // beq/bne with both Zero values
        for (int f = 0; f < 2; f++)
            for (int z = 0; z < 2; z++) begin
                set_ir(7'b1100011, f[2:0], 1'b0);
                Zero = z[0];
                step("br_fetch", e_fetch(1, 2'b10));
                step("br_decode", e_decode(2'b10));
                step("br_branch", v((z == 1) != (f == 1), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
                                    2'b10, 3'b001, 1, 0));
            end
        Zero = 1'b0;

        // fetch stall then sw with one wait cycle
        set_ir(7'b0100011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        step("sw_fetch_wait", e_fetch(0, 2'b01));
        mem_ready = 1'b1;
        step("sw_fetch", e_fetch(1, 2'b01));
        step("sw_decode", e_decode(2'b01));
        step("sw_memadr", e_exec(2'b01, 2'b01, 3'b000));
        mem_ready = 1'b0;
        step("sw_memwrite_w", v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
        mem_ready = 1'b1;
        step("sw_memwrite_ok", v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1, 0));

        // sub x0,x1,x2 (0x40208033)
        set_ir(7'b0110011, 3'b000, 1'b1);
        step("sub_fetch", e_fetch(1, 2'b00));
        step("sub_decode", e_decode(2'b00));
        step("sub_execr", e_exec(2'b00, 2'b00, 3'b001));
        step("sub_aluwb", e_aluwb(2'b00));

        // I-type funct decode: funct7b5 must not turn addi into sub
        for (int i = 0; i < 4; i++) begin
            set_ir(7'b0010011, itab_f3[i], itab_f7[i]);
            step("ialu_fetch", e_fetch(1, 2'b00));
            step("ialu_decode", e_decode(2'b00));
            step("ialu_execi", e_exec(2'b01, 2'b00, itab_alu[i]));
            step("ialu_aluwb", e_aluwb(2'b00));
        end

        // jal
        set_ir(7'b1101111, 3'b000, 1'b0);
        step("jal_fetch", e_fetch(1, 2'b11));
        step("jal_decode", e_decode(2'b11));
        step("jal_jal", v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0));
        step("jal_aluwb", e_aluwb(2'b11));

        // reset asserted mid-MEMWRITE
        set_ir(7'b0100011, 3'b010, 1'b0);
        step("swr_fetch", e_fetch(1, 2'b01));
        step("swr_decode", e_decode(2'b01));
        step("swr_memadr", e_exec(2'b01, 2'b01, 3'b000));
        mem_ready = 1'b0;
        step("swr_memwrite", v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
        reset = 1'b0;
        mem_ready = 1'b1;
        step("swr_in_reset", e_fetch(0, 2'b01));
        reset = 1'b1;

        // unsupported opcode traps and stays trapped
        set_ir(7'b1111111, 3'b000, 1'b0);
        step("trap_fetch", e_fetch(1, 2'b00));
        step("trap_decode", e_decode(2'b00));
        for (int i = 0; i < 3; i++)
            step("trap_hold", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));
        reset = 1'b0;
        step("trap_reset", e_fetch(0, 2'b00));
        reset = 1'b1;

        // unsupported funct3 (slli) traps instead of writing back
        set_ir(7'b0010011, 3'b001, 1'b0);
        step("slli_fetch", e_fetch(1, 2'b00));
        step("slli_decode", e_decode(2'b00));
        step("slli_execi", e_exec(2'b01, 2'b00, 3'b000));
        step("slli_trap", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
